// File: rtl/psk_pkg.sv
// Shared encodings and symbol-mapping helpers for the PSK modulator.
// Phase helpers return 32-bit values; callers truncate to their phase width.
package psk_pkg;

  typedef enum logic [1:0] {
    MODE_BPSK = 2'd0,
    MODE_QPSK = 2'd1,
    MODE_8PSK = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  // Reserved mode behaves as QPSK.
  function automatic logic [1:0] bps_of(input logic [1:0] mode);
    logic [1:0] bps;
    case (mode)
      MODE_BPSK: bps = 2'd1;
      MODE_8PSK: bps = 2'd3;
      default:   bps = 2'd2;
    endcase
    return bps;
  endfunction

  function automatic logic [2:0] gray_index(input logic [1:0] bps, input logic [2:0] g);
    logic [2:0] b;
    case (bps)
      2'd1:    b = {2'b00, g[0]};
      2'd2:    b = {1'b0, g[1], g[1] ^ g[0]};
      default: b = {g[2], g[2] ^ g[1], g[2] ^ g[1] ^ g[0]};
    endcase
    return b;
  endfunction

  function automatic int unsigned offset_of(input logic [1:0] bps, input int unsigned pw);
    int unsigned off;
    case (bps)
      2'd1:    off = 32'd0;
      2'd2:    off = 32'd1 << (pw - 32'd3);
      default: off = 32'd1 << (pw - 32'd4);
    endcase
    return off;
  endfunction

  // index * (2**pw / M) + offset, with M = 2**bps
  function automatic int unsigned phase_of(input logic [1:0] bps, input logic [2:0] g,
                                           input int unsigned pw);
    int unsigned idx;
    idx = 32'(gray_index(bps, g));
    return (idx << (pw - 32'(bps))) + offset_of(bps, pw);
  endfunction

endpackage

// File: rtl/psk_sin_lut.sv
// Quarter-wave sine ROM with quadrant mirroring/negation and a registered output.
// The ROM holds N+1 points so the peak at a quarter turn needs no special case.
module psk_sin_lut
  import psk_pkg::*;
#(
  parameter int DATA_W  = 11,
  parameter int PHASE_W = 10
)(
  input  logic                     Clk,
  input  logic                     rst,
  input  logic [PHASE_W-1:0]       addr_p0,
  input  logic                     vld_p0,
  output logic signed [DATA_W-1:0] sample_p1
);

  localparam int  QW      = PHASE_W - 2;
  localparam int  N       = 1 << QW;
  localparam real AMP     = real'((1 << (DATA_W - 1)) - 1);
  localparam real HALF_PI = 1.5707963267948966;

  function automatic real sin_taylor(input real x);
    real term;
    real sum;
    term = x;
    sum  = x;
    for (int k = 1; k < 10; k++) begin
      term = -term * x * x / real'((2 * k) * (2 * k + 1));
      sum  = sum + term;
    end
    return sum;
  endfunction

  function automatic logic [DATA_W-2:0] round_mag(input real v);
    return (DATA_W - 1)'($rtoi(v + 0.5));
  endfunction

  function automatic logic [DATA_W-2:0] rom_val(input int i);
    return round_mag(AMP * sin_taylor(HALF_PI * real'(i) / real'(N)));
  endfunction

  logic [DATA_W-2:0] rom [0:N];

  for (genvar i = 0; i <= N; i++) begin : g_rom
    assign rom[i] = rom_val(i);
  end

  logic [1:0]               quad;
  logic [QW:0]              sel;
  logic signed [DATA_W-1:0] mag_s;
  logic signed [DATA_W-1:0] sample_p1_d;
  logic signed [DATA_W-1:0] sample_p1_q;

  always_comb begin
    quad        = addr_p0[PHASE_W-1:PHASE_W-2];
    sel         = quad[0] ? ((QW + 1)'(N) - {1'b0, addr_p0[QW-1:0]})
                          : {1'b0, addr_p0[QW-1:0]};
    mag_s       = signed'({1'b0, rom[sel]});
    sample_p1_d = '0;
    if (vld_p0) begin
      sample_p1_d = quad[1] ? -mag_s : mag_s;
    end
  end

  // ---- stage p1: registered sample ----
  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      sample_p1_q <= '0;
    end else begin
      sample_p1_q <= sample_p1_d;
    end
  end

  assign sample_p1 = sample_p1_q;

endmodule

// File: rtl/psk_mod_param.sv
// Serial-in BPSK/QPSK/8PSK modulator: bit assembler, one-deep pending buffer,
// symbol timer with IDLE/ACTIVE control, free-running carrier and sine LUT.
module psk_mod_param
  import psk_pkg::*;
#(
  parameter int DATA_W    = 11,
  parameter int PHASE_W   = 10,
  parameter int SPS       = 400,
  parameter int PHASE_INC = 2**PHASE_W / 40
)(
  input  logic                     Clk,
  input  logic                     rst,
  input  logic [1:0]               mode,
  input  logic                     data,
  input  logic                     data_valid,
  output logic                     data_ready,
  output logic signed [DATA_W-1:0] data_out,
  output logic                     sym_strobe,
  output logic                     underrun
);

  localparam logic [15:0]        CNT_LAST = 16'(SPS - 1);
  localparam logic [PHASE_W-1:0] INC      = PHASE_W'(PHASE_INC);

  logic [PHASE_W-1:0] acc_q, acc_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [2:0]         asm_bits_q, asm_bits_d;
  logic [1:0]         asm_cnt_q, asm_cnt_d;
  logic [1:0]         asm_bps_q, asm_bps_d;
  logic               pend_vld_q, pend_vld_d;
  logic [2:0]         pend_bits_q, pend_bits_d;
  logic [1:0]         pend_bps_q, pend_bps_d;
  state_e             state_q, state_d;
  logic [PHASE_W-1:0] sym_phase_q, sym_phase_d;
  logic               seen_q, seen_d;
  logic               underrun_q, underrun_d;
  logic               rdy_en_q;
  logic [PHASE_W-1:0] addr_p0_q, addr_p0_d;
  logic               vld_p0_q, vld_p0_d;
  logic               stb_p0_q, stb_p0_d;
  logic               stb_p1_q;

  logic boundary;
  logic pend_free;
  logic asm_full;
  logic accept;

  assign boundary   = (cnt_q == CNT_LAST);
  assign pend_free  = !pend_vld_q || boundary;
  assign asm_full   = (asm_cnt_q != 2'd0) && (asm_cnt_q == asm_bps_q);
  assign data_ready = rdy_en_q && !(asm_full && !pend_free);
  assign accept     = data_valid && data_ready;

  always_comb begin
    acc_d       = acc_q + INC;
    cnt_d       = boundary ? 16'd0 : cnt_q + 16'd1;
    asm_bits_d  = asm_bits_q;
    asm_cnt_d   = asm_cnt_q;
    asm_bps_d   = asm_bps_q;
    pend_vld_d  = pend_vld_q && !boundary;
    pend_bits_d = pend_bits_q;
    pend_bps_d  = pend_bps_q;
    state_d     = state_q;
    sym_phase_d = sym_phase_q;
    seen_d      = seen_q;
    underrun_d  = underrun_q;
    stb_p0_d    = 1'b0;

    if (boundary) begin
      if (pend_vld_q) begin
        state_d     = ST_ACTIVE;
        sym_phase_d = PHASE_W'(phase_of(pend_bps_q, pend_bits_q, PHASE_W));
        seen_d      = 1'b1;
        stb_p0_d    = 1'b1;
      end else begin
        state_d    = ST_IDLE;
        underrun_d = underrun_q || seen_q;
      end
    end

    // A symbol that was stalled in the assembler leaves first.
    if (asm_full && pend_free) begin
      pend_vld_d  = 1'b1;
      pend_bits_d = asm_bits_q;
      pend_bps_d  = asm_bps_q;
      asm_cnt_d   = 2'd0;
      asm_bits_d  = 3'd0;
    end

    if (accept) begin
      if (asm_cnt_d == 2'd0) begin
        asm_bps_d  = bps_of(mode);
        asm_bits_d = {2'b00, data};
        asm_cnt_d  = 2'd1;
      end else begin
        asm_bits_d = {asm_bits_d[1:0], data};
        asm_cnt_d  = asm_cnt_d + 2'd1;
      end
      if ((asm_cnt_d == asm_bps_d) && !asm_full && pend_free) begin
        pend_vld_d  = 1'b1;
        pend_bits_d = asm_bits_d;
        pend_bps_d  = asm_bps_d;
        asm_cnt_d   = 2'd0;
        asm_bits_d  = 3'd0;
      end
    end

    addr_p0_d = acc_q + sym_phase_d;
    vld_p0_d  = (state_d == ST_ACTIVE);
  end

  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      asm_bits_q  <= '0;
      asm_cnt_q   <= '0;
      asm_bps_q   <= '0;
      pend_vld_q  <= 1'b0;
      pend_bits_q <= '0;
      pend_bps_q  <= '0;
      state_q     <= ST_IDLE;
      sym_phase_q <= '0;
      seen_q      <= 1'b0;
      underrun_q  <= 1'b0;
      rdy_en_q    <= 1'b0;
      addr_p0_q   <= '0;
      vld_p0_q    <= 1'b0;
      stb_p0_q    <= 1'b0;
      stb_p1_q    <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      asm_bits_q  <= asm_bits_d;
      asm_cnt_q   <= asm_cnt_d;
      asm_bps_q   <= asm_bps_d;
      pend_vld_q  <= pend_vld_d;
      pend_bits_q <= pend_bits_d;
      pend_bps_q  <= pend_bps_d;
      state_q     <= state_d;
      sym_phase_q <= sym_phase_d;
      seen_q      <= seen_d;
      underrun_q  <= underrun_d;
      rdy_en_q    <= 1'b1;
      // ---- stage p0: LUT address ----
      addr_p0_q   <= addr_p0_d;
      vld_p0_q    <= vld_p0_d;
      stb_p0_q    <= stb_p0_d;
      // ---- stage p1: sample out ----
      stb_p1_q    <= stb_p0_q;
    end
  end

  psk_sin_lut #(
    .DATA_W  (DATA_W),
    .PHASE_W (PHASE_W)
  ) u_lut (
    .Clk       (Clk),
    .rst       (rst),
    .addr_p0   (addr_p0_q),
    .vld_p0    (vld_p0_q),
    .sample_p1 (data_out)
  );

  assign sym_strobe = stb_p1_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_psk_mod_param.sv
// Randomized bench for psk_mod_param against a symbol-level reference model.
module tb_psk_mod_param;

  localparam int DW   = 11;
  localparam int PW   = 10;
  localparam int SPS  = 400;
  localparam int INC  = (1 << PW) / 40;
  localparam int AMP  = (1 << (DW - 1)) - 1;
  localparam int FULL = 1 << PW;

  logic                 Clk = 1'b0;
  logic                 rst;
  logic [1:0]           mode;
  logic                 data;
  logic                 data_valid;
  logic                 data_ready;
  logic signed [DW-1:0] data_out;
  logic                 sym_strobe;
  logic                 underrun;

  always #5 Clk = ~Clk;

  psk_mod_param #(
    .DATA_W    (DW),
    .PHASE_W   (PW),
    .SPS       (SPS),
    .PHASE_INC (INC)
  ) dut (
    .Clk        (Clk),
    .rst        (rst),
    .mode       (mode),
    .data       (data),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .data_out   (data_out),
    .sym_strobe (sym_strobe),
    .underrun   (underrun)
  );

  int n_checks;
  int n_errors;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int n;
  int sym_ph[$];
  int sym_done[$];
  int a_cnt, a_bps, a_bits;
  bit m_act, m_seen, m_und;
  int m_phase;
  int e_out[$];
  int e_stb[$];
  int e_addr[$];

  function automatic int ref_sample(input int a);
    real v;
    v = real'(AMP) * $sin(2.0 * 3.14159265358979323846 * real'(a % FULL) / real'(FULL));
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
  endfunction

  function automatic int ref_bps(input logic [1:0] m);
    return (m == 2'd0) ? 1 : ((m == 2'd2) ? 3 : 2);
  endfunction

  function automatic int ref_phase(input int bits, input int bps);
    int m, idx, off;
    m   = 1 << bps;
    idx = 0;
    for (int i = 0; i < m; i++) if ((i ^ (i >> 1)) == bits) idx = i;
    off = (bps == 1) ? 0 : ((bps == 2) ? FULL / 8 : FULL / 16);
    return (idx * (FULL / m) + off) % FULL;
  endfunction

  task automatic model_reset();
    n = 0;
    sym_ph.delete();
    sym_done.delete();
    a_cnt = 0; a_bps = 0; a_bits = 0;
    m_act = 0; m_seen = 0; m_und = 0; m_phase = 0;
    e_out  = '{0, 0};
    e_stb  = '{0, 0};
    e_addr = '{-1, -1};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    data_valid = 1'b0;
    #1;
    check_eq("rst_data_out", data_out, 0);
    check_eq("rst_sym_strobe", sym_strobe, 0);
    check_eq("rst_underrun", underrun, 0);
    check_eq("rst_data_ready", data_ready, 0);
    @(posedge Clk);
    @(posedge Clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Called 1 time unit after a rising edge; checks this cycle, drives inputs, advances.
  task automatic run_cycle(input bit v, input bit d, input logic [1:0] m, output bit acc);
    bit bnd;
    bit stb;
    int exp_rdy;
    bnd     = ((n % SPS) == SPS - 1);
    stb     = 1'b0;
    exp_rdy = (n >= 1 && !(sym_ph.size() >= 2 && !bnd)) ? 1 : 0;
    check_eq("data_out", data_out, e_out[0]);
    check_eq("sym_strobe", sym_strobe, e_stb[0]);
    check_eq("underrun", underrun, int'(m_und));
    check_eq("data_ready", data_ready, exp_rdy);
    if (e_addr[0] == 128) check_eq("sin45", data_out, 723);
    void'(e_out.pop_front());
    void'(e_stb.pop_front());
    void'(e_addr.pop_front());

    data_valid = v;
    data       = d;
    mode       = m;
    #1;
    acc = v && data_ready;

    if (bnd) begin
      if (sym_ph.size() > 0 && sym_done[0] < n) begin
        m_act   = 1'b1;
        m_phase = sym_ph.pop_front();
        void'(sym_done.pop_front());
        m_seen  = 1'b1;
        stb     = 1'b1;
      end else begin
        m_act = 1'b0;
        if (m_seen) m_und = 1'b1;
      end
    end
    if (acc) begin
      if (a_cnt == 0) begin
        a_bps  = ref_bps(m);
        a_bits = 0;
      end
      a_bits = a_bits * 2 + int'(d);
      a_cnt++;
      if (a_cnt == a_bps) begin
        sym_ph.push_back(ref_phase(a_bits, a_bps));
        sym_done.push_back(n);
        a_cnt = 0;
      end
    end
    e_out.push_back(m_act ? ref_sample(n * INC + m_phase) : 0);
    e_addr.push_back(m_act ? (n * INC + m_phase) % FULL : -1);
    e_stb.push_back(int'(stb));

    @(posedge Clk);
    #1;
    n++;
  endtask

  bit bp [3] = '{1'b1, 1'b0, 1'b1};
  bit ep [3] = '{1'b1, 1'b1, 1'b0};

  initial begin
    bit a;
    int rem;
    int idx;
    int low;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    data_valid = 1'b0;
    data = 1'b0;
    mode = 2'd0;
    repeat (2) @(posedge Clk);
    #1;
    do_reset();

    // QPSK 00 x3, starve for underrun, then resume with 01
    rem = 6;
    for (int c = 0; c < 2100; c++) begin
      run_cycle(rem > 0, 1'b0, 2'd1, a);
      if (a) rem--;
    end
    check_eq("qpsk_bits_taken", rem, 0);
    rem = 2;
    for (int c = 0; c < 900; c++) begin
      run_cycle(rem > 0, rem == 1, 2'd1, a);
      if (a) rem--;
    end
    check_eq("resume_bits_taken", rem, 0);

    // BPSK 1,0,1
    do_reset();
    idx = 0;
    for (int c = 0; c < 1700; c++) begin
      run_cycle(idx < 3, (idx < 3) ? bp[idx] : 1'b0, 2'd0, a);
      if (a) idx++;
    end

    // 8PSK 1,1,0
    do_reset();
    idx = 0;
    for (int c = 0; c < 900; c++) begin
      run_cycle(idx < 3, (idx < 3) ? ep[idx] : 1'b0, 2'd2, a);
      if (a) idx++;
    end

    // reset while a symbol plays and one QPSK bit is half-assembled
    do_reset();
    rem = 3;
    for (int c = 0; c < 450; c++) begin
      run_cycle(rem > 0, 1'b1, 2'd1, a);
      if (a) rem--;
    end
    do_reset();
    rem = 2;
    for (int c = 0; c < 900; c++) begin
      run_cycle(rem > 0, 1'b0, 2'd1, a);
      if (a) rem--;
    end

    // continuous valid, random bits and modes changing every cycle
    do_reset();
    low = 0;
    for (int c = 0; c < 17 * SPS; c++) begin
      if (n > 0 && !data_ready) low++;
      run_cycle(1'b1, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), a);
    end
    check_eq("ready_dropped", int'(low > 0), 1);

    // sparse random traffic with gaps and underruns
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      run_cycle($urandom_range(0, 149) == 0, $urandom_range(0, 1) == 1,
                2'($urandom_range(0, 3)), a);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
